// File: rtl/arb_mux_n.sv
// N-way registered selector: direct / fixed-priority / round-robin grant
// feeding a one-deep output register with valid/ready handshakes.
module arb_mux_n #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  typedef enum logic [1:0] {
    MODE_DIRECT     = 2'b00,
    MODE_PRIO       = 2'b01,
    MODE_RR         = 2'b10,
    MODE_DIRECT_ALT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic [SEL_W-1:0] rr_q, rr_d;

  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             load_ok;
  logic             xfer;

  assign load_ok = ~out_valid_q | out_ready;
  assign xfer    = load_ok & gnt_vld;

  always_comb begin
    int unsigned sel_u;
    int unsigned j;
    logic [SEL_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sel_u   = 32'(sel);
    j       = 0;
    idx     = '0;
    case (mode_e'(mode))
      MODE_PRIO: begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          idx = SEL_W'(i);
          if (!gnt_vld && in_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
          end
        end
      end
      MODE_RR: begin
        // Search starts at rr_q; wrap is modulo NUM_IN, not 2**SEL_W.
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          j = 32'(rr_q) + i;
          if (j >= NUM_IN) j = j - NUM_IN;
          idx = SEL_W'(j);
          if (!gnt_vld && in_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
          end
        end
      end
      default: begin
        if (sel_u < NUM_IN && in_valid[sel]) begin
          gnt_vld = 1'b1;
          gnt_idx = sel;
        end
      end
    endcase
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready = (xfer && !reset) ? (NUM_IN'(1) << gnt_idx) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_src_d   = gnt_idx;
      out_valid_d = 1'b1;
      rr_d        = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      rr_q        <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      rr_q        <= rr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: a 4-channel and a 3-channel instance checked every
// cycle against a queue-free behavioural model, plus directed literal checks.
module tb_arb_mux_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data4 = '0;
  logic [3:0]  in_valid4 = '0;
  logic [1:0]  sel = '0;
  logic [1:0]  mode = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  in_ready4;
  logic [2:0]  in_ready3;
  logic [15:0] out_data4, out_data3;
  logic        out_valid4, out_valid3;
  logic [1:0]  out_src4, out_src3;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_v [2];
  logic [15:0] m_d [2];
  int          m_s [2];
  int          m_p [2];

  always #5 clk = ~clk;

  arb_mux_n #(.WIDTH(16), .NUM_IN(4)) u4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .sel(sel), .mode(mode), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_src(out_src4)
  );

  arb_mux_n #(.WIDTH(16), .NUM_IN(3)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data4[47:0]), .in_valid(in_valid4[2:0]),
    .in_ready(in_ready3), .sel(sel), .mode(mode), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_src(out_src3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Grant rules straight from the channel-selection description; -1 = none.
  function automatic int mgrant(input int n, input logic [3:0] v, input logic [1:0] md,
                                input int s, input int p);
    if (md == 2'b01) begin
      for (int i = 0; i < n; i++) if (v[i]) return i;
    end else if (md == 2'b10) begin
      for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    end else if (s < n && v[s]) begin
      return s;
    end
    return -1;
  endfunction

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_v[u] = 1'b0; m_d[u] = '0; m_s[u] = 0; m_p[u] = 0;
    end
  end

  // Inputs only change just after posedge, so negedge values hold through the next edge.
  always @(negedge clk) begin : cmp
    int          n, g;
    logic        lok;
    logic [3:0]  v, exp_rdy, act_rdy;
    logic [15:0] act_d;
    logic        act_v;
    logic [1:0]  act_s;
    for (int u = 0; u < 2; u++) begin
      n       = (u == 0) ? 4 : 3;
      v       = (u == 0) ? in_valid4 : {1'b0, in_valid4[2:0]};
      act_rdy = (u == 0) ? in_ready4 : {1'b0, in_ready3};
      act_d   = (u == 0) ? out_data4 : out_data3;
      act_v   = (u == 0) ? out_valid4 : out_valid3;
      act_s   = (u == 0) ? out_src4 : out_src3;
      if (reset) begin
        m_v[u] = 1'b0; m_d[u] = '0; m_s[u] = 0; m_p[u] = 0;
      end
      g       = reset ? -1 : mgrant(n, v, mode, int'(sel), m_p[u]);
      lok     = !m_v[u] || out_ready;
      exp_rdy = (lok && g >= 0) ? 4'(1 << g) : 4'b0;
      chk($sformatf("in_ready_n%0d", n), 32'(act_rdy), 32'(exp_rdy));
      chk($sformatf("out_valid_n%0d", n), 32'(act_v), 32'(m_v[u]));
      chk($sformatf("out_data_n%0d", n), 32'(act_d), 32'(m_d[u]));
      chk($sformatf("out_src_n%0d", n), 32'(act_s), 32'(m_s[u]));
      if (lok && g >= 0) begin
        m_v[u] = 1'b1;
        m_d[u] = in_data4[g*16 +: 16];
        m_s[u] = g;
        m_p[u] = (g + 1) % n;
      end else if (!reset && out_ready) begin
        m_v[u] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin : stim
    int seq [5];
    seq = '{0, 1, 2, 3, 0};

    // Reset state, with requests present
    mode = 2'b01; in_valid4 = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready4), 32'h0);
    chk("rst_out_valid", 32'(out_valid4), 32'h0);
    chk("rst_out_data", 32'(out_data4), 32'h0);
    chk("rst_out_src", 32'(out_src4), 32'h0);
    step();
    reset = 1'b0; in_valid4 = '0;

    // Direct mode, sel=2
    step();
    mode = 2'b00; sel = 2'd2; in_data4 = {16'h0, 16'hABCD, 16'h0, 16'h0};
    in_valid4 = 4'b0100; out_ready = 1'b1;
    @(negedge clk);
    chk("dir_in_ready", 32'(in_ready4), 32'h4);
    step();
    in_valid4 = '0;
    @(negedge clk);
    chk("dir_out_data", 32'(out_data4), 32'hABCD);
    chk("dir_out_src", 32'(out_src4), 32'h2);
    chk("dir_out_valid", 32'(out_valid4), 32'h1);

    // Fixed priority: ch1 always wins over ch3
    step();
    mode = 2'b01; in_data4 = {16'h3333, 16'h0, 16'h1111, 16'h0}; in_valid4 = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prio_in_ready", 32'(in_ready4), 32'h2);
      if (k > 0) begin
        chk("prio_out_data", 32'(out_data4), 32'h1111);
        chk("prio_out_src", 32'(out_src4), 32'h1);
      end
    end

    // Round-robin fairness from rr_ptr=0
    do_reset();
    mode = 2'b10; in_data4 = {16'd3, 16'd2, 16'd1, 16'd0}; in_valid4 = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    chk("rr_first_ready", 32'(in_ready4), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_out_src", 32'(out_src4), 32'(seq[k]));
      chk("rr_out_data", 32'(out_data4), 32'(seq[k]));
    end

    // Asynchronous reset between edges drops out_valid at once
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid4), 32'h0);
    chk("async_out_data", 32'(out_data4), 32'h0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("async_first_grant", 32'(in_ready4), 32'h1);

    // Backpressure: 5555 held for three stalled cycles, then 7777 with no bubble
    step();
    mode = 2'b00; sel = 2'd0; in_data4 = {48'h0, 16'h5555}; in_valid4 = 4'b0001; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_data4 = {48'h0, 16'h7777};
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(out_data4), 32'h5555);
      chk("bp_hold_valid", 32'(out_valid4), 32'h1);
      chk("bp_in_ready", 32'(in_ready4), 32'h0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready4), 32'h1);
    @(negedge clk);
    chk("bp_new_data", 32'(out_data4), 32'h7777);
    chk("bp_new_valid", 32'(out_valid4), 32'h1);

    // Out-of-range sel on the 3-channel instance
    do_reset();
    mode = 2'b00; sel = 2'd3; in_valid4 = 4'hF; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("oor_in_ready3", 32'(in_ready3), 32'h0);
      chk("oor_out_valid3", 32'(out_valid3), 32'h0);
    end

    // Randomised traffic, occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      step();
      mode      = 2'($urandom);
      sel       = 2'($urandom);
      in_valid4 = 4'($urandom);
      in_data4  = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
